// File: rtl/sb_rx_pkg.sv
// Shared types and header field layout for the sideband RX message path.
package sb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_GEN,
    ST_ADPT,
    ST_RDI,
    ST_HDR,
    ST_DATA
  } sb_rx_state_t;

  localparam logic [63:0] SB_PATTERN   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [4:0]  OPC_MSG_DATA = 5'b11011;
  localparam logic [3:0]  SUBCODE_RSP  = 4'hA;
  localparam logic [3:0]  LTSM_RESET   = 4'h0;

  localparam int OPC_MSB = 4;
  localparam int OPC_LSB = 0;
  localparam int MSG_MSB = 21;
  localparam int MSG_LSB = 18;
  localparam int SUB_MSB = 17;
  localparam int SUB_LSB = 14;
  localparam int DST_MSB = 58;
  localparam int DST_LSB = 56;
  localparam int DP_BIT  = 63;

  // Header parity covers everything below the data-parity bit.
  function automatic logic hdr_parity_ok(input logic [63:0] d);
    return ~^d[DP_BIT-1:0];
  endfunction

endpackage

// File: rtl/sb_rx_pattern_det.sv
// Combinational clock-pattern detector; shared with the TX loopback checker.
module sb_rx_pattern_det
  import sb_rx_pkg::*;
(
  input  logic [63:0] data,
  output logic        is_pattern
);

  // Alternating pattern: every bit equals the one two positions above, MSB set.
  assign is_pattern = data[DP_BIT] & (data[DP_BIT-2:0] == data[DP_BIT:2]);

endmodule

// File: rtl/sb_rx_msg_ctrl.sv
// Sideband RX message controller: pattern lock, word classification, decoder
// sequencing with timeout, and a saturating parity/timeout error counter.
module sb_rx_msg_ctrl
  import sb_rx_pkg::*;
#(
  parameter int PATTERN_REPS = 2,
  parameter int DATA_WORDS   = 1,
  parameter int DEC_TIMEOUT  = 64,
  parameter int ERR_CW       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_de_ser_done,
  input  logic [63:0]       i_deser_data,
  input  logic [3:0]        i_state,
  input  logic              i_header_valid,
  input  logic              i_rdi_valid,
  input  logic              i_data_valid,
  output logic              o_de_ser_done_sampled,
  output logic              o_rx_sb_start_pattern,
  output logic              o_rx_sb_pattern_samp_done,
  output logic              o_header_enable,
  output logic              o_rdi_enable,
  output logic              o_data_enable,
  output logic [2:0]        o_data_word_idx,
  output logic              o_adapter_enable,
  output logic              o_msg_valid,
  output logic              o_rx_rsp_delivered,
  output logic              o_parity_error,
  output logic              o_timeout_error,
  output logic [ERR_CW-1:0] o_err_count
);

  localparam int REP_W = $clog2(PATTERN_REPS + 1);
  localparam int TMO_W = $clog2(DEC_TIMEOUT);

  sb_rx_state_t      state;
  logic [REP_W-1:0]  rep_cnt;
  logic [3:0]        word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              dp;

  logic              is_pattern;
  logic [4:0]        opcode;
  logic [3:0]        msgcode;
  logic [3:0]        subcode;
  logic              adapter_dst;
  logic              hdr_par_ok;
  logic              data_par_ok;
  logic              tmo_hit;
  logic              words_done;
  logic              ltsm_reset;
  logic [ERR_CW-1:0] err_count_inc;

  sb_rx_pattern_det u_pattern_det (
    .data       (i_deser_data),
    .is_pattern (is_pattern)
  );

  assign opcode        = i_deser_data[OPC_MSB:OPC_LSB];
  assign msgcode       = i_deser_data[MSG_MSB:MSG_LSB];
  assign subcode       = i_deser_data[SUB_MSB:SUB_LSB];
  assign adapter_dst   = i_deser_data[DST_LSB];
  assign hdr_par_ok    = hdr_parity_ok(i_deser_data);
  assign data_par_ok   = ~^{i_deser_data, dp};
  assign tmo_hit       = (tmo_cnt == TMO_W'(DEC_TIMEOUT - 1));
  assign words_done    = (word_cnt == 4'(DATA_WORDS));
  assign ltsm_reset    = (i_state == LTSM_RESET);
  assign err_count_inc = (&o_err_count) ? o_err_count : o_err_count + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                     <= ST_IDLE;
      rep_cnt                   <= '0;
      word_cnt                  <= '0;
      tmo_cnt                   <= '0;
      dp                        <= 1'b0;
      o_de_ser_done_sampled     <= 1'b0;
      o_rx_sb_start_pattern     <= 1'b0;
      o_rx_sb_pattern_samp_done <= 1'b0;
      o_header_enable           <= 1'b0;
      o_rdi_enable              <= 1'b0;
      o_data_enable             <= 1'b0;
      o_data_word_idx           <= '0;
      o_adapter_enable          <= 1'b0;
      o_msg_valid               <= 1'b0;
      o_rx_rsp_delivered        <= 1'b0;
      o_parity_error            <= 1'b0;
      o_timeout_error           <= 1'b0;
      o_err_count               <= '0;
    end else begin
      o_de_ser_done_sampled     <= i_de_ser_done;
      o_rx_sb_start_pattern     <= 1'b0;
      o_rx_sb_pattern_samp_done <= 1'b0;
      o_header_enable           <= 1'b0;
      o_rdi_enable              <= 1'b0;
      o_data_enable             <= 1'b0;
      o_adapter_enable          <= 1'b0;
      o_msg_valid               <= 1'b0;
      o_rx_rsp_delivered        <= 1'b0;
      o_parity_error            <= 1'b0;
      o_timeout_error           <= 1'b0;

      // LTSM falling back to RESET drops any message in flight silently.
      if (ltsm_reset && (state inside {ST_GEN, ST_RDI, ST_HDR, ST_DATA})) begin
        state    <= ST_IDLE;
        rep_cnt  <= '0;
        word_cnt <= '0;
        tmo_cnt  <= '0;
        dp       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_de_ser_done && is_pattern) begin
              o_rx_sb_start_pattern <= ltsm_reset;
              if (PATTERN_REPS == 1) begin
                state                     <= ST_GEN;
                o_rx_sb_pattern_samp_done <= 1'b1;
              end else begin
                state   <= ST_HUNT;
                rep_cnt <= REP_W'(1);
              end
            end
          end

          ST_HUNT: begin
            if (i_de_ser_done) begin
              if (!is_pattern) begin
                rep_cnt <= REP_W'(1);
              end else if (rep_cnt == REP_W'(PATTERN_REPS - 1)) begin
                state                     <= ST_GEN;
                rep_cnt                   <= '0;
                o_rx_sb_pattern_samp_done <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end

          ST_GEN: begin
            if (i_de_ser_done && !is_pattern) begin
              if (adapter_dst) begin
                state            <= ST_ADPT;
                o_adapter_enable <= 1'b1;
              end else if (!hdr_par_ok) begin
                o_parity_error <= 1'b1;
                o_err_count    <= err_count_inc;
              end else if (msgcode == 4'h0) begin
                state        <= ST_RDI;
                tmo_cnt      <= '0;
                o_rdi_enable <= 1'b1;
              end else begin
                state              <= ST_HDR;
                tmo_cnt            <= '0;
                dp                 <= i_deser_data[DP_BIT];
                o_header_enable    <= 1'b1;
                o_rx_rsp_delivered <= (subcode == SUBCODE_RSP);
              end
            end
          end

          ST_ADPT: state <= ST_GEN;

          ST_RDI: begin
            if (i_rdi_valid) begin
              state       <= ST_GEN;
              o_msg_valid <= 1'b1;
            end else if (tmo_hit) begin
              state           <= ST_GEN;
              o_timeout_error <= 1'b1;
              o_err_count     <= err_count_inc;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          ST_HDR: begin
            if (i_header_valid) begin
              if (opcode == OPC_MSG_DATA) begin
                state    <= ST_DATA;
                word_cnt <= '0;
                tmo_cnt  <= '0;
              end else begin
                state       <= ST_GEN;
                o_msg_valid <= 1'b1;
              end
            end else if (tmo_hit) begin
              state           <= ST_GEN;
              o_timeout_error <= 1'b1;
              o_err_count     <= err_count_inc;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          ST_DATA: begin
            // Valids and accepted words are evaluated ahead of the timeout.
            if (words_done && i_data_valid) begin
              state       <= ST_GEN;
              o_msg_valid <= 1'b1;
            end else if (!words_done && i_de_ser_done) begin
              if (data_par_ok) begin
                o_data_enable   <= 1'b1;
                o_data_word_idx <= word_cnt[2:0];
                word_cnt        <= word_cnt + 4'd1;
                tmo_cnt         <= '0;
              end else begin
                state          <= ST_GEN;
                o_parity_error <= 1'b1;
                o_err_count    <= err_count_inc;
              end
            end else if (tmo_hit) begin
              state           <= ST_GEN;
              o_timeout_error <= 1'b1;
              o_err_count     <= err_count_inc;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
